// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the keyboard clock, decodes
// 11-bit frames, and tracks make/break codes to present the current key.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_data,
  output logic [7:0] prev_data,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TO_MAX   = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data byte plus parity bit carry an odd count of ones.
  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  logic           clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic           data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic           clk_filt_q, clk_filt_d, clk_filt_prev_q, clk_filt_prev_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           break_q, break_d;
  logic [7:0]     key_q, key_d, prev_q, prev_d;
  logic           key_valid_q, key_valid_d, frame_error_q, frame_error_d;
  logic           fall_s, timeout_s;

  // Synchroniser chains and glitch filter on the keyboard clock.
  always_comb begin
    clk_meta_d      = ps2_clk;
    clk_sync_d      = clk_meta_q;
    data_meta_d     = ps2_data;
    data_sync_d     = data_meta_q;
    clk_filt_prev_d = clk_filt_q;
    clk_filt_d      = clk_filt_q;
    filt_cnt_d      = filt_cnt_q;
    if (clk_sync_q == clk_filt_q) begin
      filt_cnt_d = {FCW{1'b0}};
    end else if (filt_cnt_q == FILT_MAX) begin
      clk_filt_d = clk_sync_q;
      filt_cnt_d = {FCW{1'b0}};
    end else begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end
  end

  assign fall_s    = clk_filt_prev_q & ~clk_filt_q;
  assign timeout_s = (state_q != ST_IDLE) && !fall_s && (to_cnt_q == TO_MAX);

  // Frame decoder, timeout watchdog and make/break key tracking.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    break_d       = break_q;
    key_d         = key_q;
    prev_d        = prev_q;
    key_valid_d   = 1'b0;
    frame_error_d = 1'b0;
    if (state_q == ST_IDLE || fall_s) begin
      to_cnt_d = {TCW{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TCW'(1);
    end

    if (timeout_s) begin
      state_d       = ST_IDLE;
      bit_cnt_d     = 3'd0;
      to_cnt_d      = {TCW{1'b0}};
      frame_error_d = 1'b1;
    end else if (fall_s) begin
      case (state_q)
        ST_IDLE: begin
          if (!data_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          parity_d = data_sync_q;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (parity_ok(shift_q, parity_q) && data_sync_q) begin
            case (shift_q)
              8'hF0:   break_d = 1'b1;
              8'hE0:   break_d = break_q;
              default: begin
                prev_d      = key_q;
                key_d       = break_q ? 8'h00 : shift_q;
                key_valid_d = 1'b1;
                break_d     = 1'b0;
              end
            endcase
          end else begin
            frame_error_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register; the bus-idle level of the synchronisers is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q      <= 1'b1;
      clk_sync_q      <= 1'b1;
      data_meta_q     <= 1'b1;
      data_sync_q     <= 1'b1;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= {FCW{1'b0}};
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'h00;
      parity_q        <= 1'b0;
      to_cnt_q        <= {TCW{1'b0}};
      break_q         <= 1'b0;
      key_q           <= 8'h00;
      prev_q          <= 8'h00;
      key_valid_q     <= 1'b0;
      frame_error_q   <= 1'b0;
    end else begin
      clk_meta_q      <= clk_meta_d;
      clk_sync_q      <= clk_sync_d;
      data_meta_q     <= data_meta_d;
      data_sync_q     <= data_sync_d;
      clk_filt_q      <= clk_filt_d;
      clk_filt_prev_q <= clk_filt_prev_d;
      filt_cnt_q      <= filt_cnt_d;
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_q        <= parity_d;
      to_cnt_q        <= to_cnt_d;
      break_q         <= break_d;
      key_q           <= key_d;
      prev_q          <= prev_d;
      key_valid_q     <= key_valid_d;
      frame_error_q   <= frame_error_d;
    end
  end

  assign key_data    = key_q;
  assign prev_data   = prev_q;
  assign key_valid   = key_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: good, break, bad-parity, timeout,
// glitch, start-error and mid-frame-reset frames with hand-computed results.
module tb_ps2_key_receiver;

  localparam int FL = 4;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_data, prev_data;
  logic       key_valid, frame_error;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int kv_base, fe_base;

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_data(key_data), .prev_data(prev_data),
    .key_valid(key_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (key_valid === 1'b1) kv_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (key_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
    cycles(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(stop);
    ps2_data = 1'b1;
    cycles(10);
  endtask

  task automatic mark;
    kv_base = kv_cnt;
    fe_base = fe_cnt;
  endtask

  initial begin
    logic [7:0] b6b;
    cycles(5);
    check("reset_key", {24'd0, key_data}, 32'h00);
    check("reset_prev", {24'd0, prev_data}, 32'h00);
    check("reset_kv", {31'd0, key_valid}, 32'd0);
    check("reset_fe", {31'd0, frame_error}, 32'd0);
    rst_n = 1'b1;
    cycles(5);

    mark();
    send_frame(8'h1D, 1'b0, 1'b1);
    check("make_key", {24'd0, key_data}, 32'h1D);
    check("make_prev", {24'd0, prev_data}, 32'h00);
    check("make_kv", kv_cnt - kv_base, 32'd1);
    check("make_fe", fe_cnt - fe_base, 32'd0);

    mark();
    send_frame(8'hF0, 1'b0, 1'b1);
    check("f0_kv", kv_cnt - kv_base, 32'd0);
    send_frame(8'h1D, 1'b0, 1'b1);
    check("brk_key", {24'd0, key_data}, 32'h00);
    check("brk_prev", {24'd0, prev_data}, 32'h1D);
    check("brk_kv", kv_cnt - kv_base, 32'd1);

    mark();
    send_frame(8'h1D, 1'b1, 1'b1);
    check("par_fe", fe_cnt - fe_base, 32'd1);
    check("par_kv", kv_cnt - kv_base, 32'd0);
    check("par_key", {24'd0, key_data}, 32'h00);
    check("par_prev", {24'd0, prev_data}, 32'h1D);

    mark();
    send_frame(8'h33, 1'b0, 1'b0);
    check("stop_fe", fe_cnt - fe_base, 32'd1);
    check("stop_kv", kv_cnt - kv_base, 32'd0);

    mark();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cycles(TO + 20);
    check("to_fe", fe_cnt - fe_base, 32'd1);
    check("to_kv", kv_cnt - kv_base, 32'd0);
    mark();
    send_frame(8'h75, 1'b0, 1'b1);
    check("to_key", {24'd0, key_data}, 32'h75);
    check("to_prev", {24'd0, prev_data}, 32'h00);
    check("to_kv2", kv_cnt - kv_base, 32'd1);
    check("to_fe2", fe_cnt - fe_base, 32'd0);

    mark();
    ps2_clk = 1'b0;
    cycles(FL - 2);
    ps2_clk = 1'b1;
    cycles(30);
    check("glitch_kv", kv_cnt - kv_base, 32'd0);
    check("glitch_fe", fe_cnt - fe_base, 32'd0);
    check("glitch_key", {24'd0, key_data}, 32'h75);

    mark();
    send_bit(1'b1);
    check("starterr_fe", fe_cnt - fe_base, 32'd1);
    check("starterr_kv", kv_cnt - kv_base, 32'd0);

    b6b = 8'h6B;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(b6b[i]);
    rst_n = 1'b0;
    cycles(3);
    check("rst_key", {24'd0, key_data}, 32'h00);
    check("rst_prev", {24'd0, prev_data}, 32'h00);
    check("rst_kv", {31'd0, key_valid}, 32'd0);
    check("rst_fe", {31'd0, frame_error}, 32'd0);
    rst_n = 1'b1;
    cycles(5);
    mark();
    send_frame(8'h6B, 1'b0, 1'b1);
    check("post_key", {24'd0, key_data}, 32'h6B);
    check("post_prev", {24'd0, prev_data}, 32'h00);
    check("post_kv", kv_cnt - kv_base, 32'd1);
    check("post_fe", fe_cnt - fe_base, 32'd0);

    check("never_both", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive clk samples ps2_clk must hold stable before a level change is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles inside a frame before abort (1 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1: keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1: keyboard data, asynchronous to clk.
REQ-007 SHALL have port key_data, output, 8: current key code, or 0x00 after a release; drives the memory inputData port.
REQ-008 SHALL have port prev_data, output, 8: the key_data value held before the most recent key_valid; drives previousData.
REQ-009 SHALL have port key_valid, output, 1: one-cycle strobe that key_data is updated; drives inputDataClk.
REQ-010 SHALL have port frame_error, output, 1: one-cycle strobe on a parity, start, stop or timeout error.

Function
REQ-011 SHALL synchronise ps2_clk and ps2_data through 2 flip-flops each before any use.
REQ-012 SHALL filter synchronised ps2_clk: the filtered level changes only after FILTER_LEN identical consecutive samples.
REQ-013 SHALL sample synchronised ps2_data on the clk cycle a filtered ps2_clk falling edge is detected; rising edges are ignored.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
- IDLE -> DATA on a falling edge with data=0 (start bit).
- A falling edge with data=1 in IDLE is a start error: pulse frame_error and stay in IDLE.
REQ-015 SHALL shift 8 data bits LSB first in DATA using a 3-bit counter, then move DATA -> PARITY -> STOP.
REQ-016 SHALL accept a frame only when parity is odd (the 8 data bits plus the parity bit hold an odd number of 1s) and the stop bit=1; STOP -> IDLE in all cases.
REQ-017 SHALL, for an accepted byte 0xF0, set break_pending and emit no key_valid.
REQ-018 SHALL, for an accepted byte 0xE0, emit no key_valid and leave break_pending unchanged.
REQ-019 SHALL, for any other accepted byte with break_pending=1, load prev_data<=key_data and key_data<=0x00, pulse key_valid, and clear break_pending.
REQ-020 SHALL, for any other accepted byte with break_pending=0, load prev_data<=key_data and key_data<=byte, and pulse key_valid.
REQ-021 SHALL assert key_valid and frame_error registered, exactly 1 cycle, on the clk cycle after the stop-bit falling edge is detected.
REQ-022 SHALL, on a rejected frame, pulse frame_error with no key_valid and leave key_data, prev_data and break_pending unchanged.
REQ-023 SHALL count clk cycles since the last falling edge while not in IDLE; on reaching TIMEOUT_CYCLES it returns to IDLE, clears the bit counter and pulses frame_error.
REQ-024 SHALL never assert key_valid and frame_error in the same cycle.
REQ-025 SHALL keep key_data and prev_data stable between key_valid pulses.

Reset
REQ-026 SHALL, while rst_n=0 and regardless of clk, force: state=IDLE; key_data=0x00; prev_data=0x00; key_valid=0; frame_error=0; break_pending=0; counters=0; synchronisers and filter=1 (bus idle).
REQ-027 SHALL, when reset is asserted mid-frame, discard the partial frame; the first frame after release is received normally.

Verification
REQ-028 SHALL pass: frame 0x1D (start 0; bits 1,0,1,1,1,0,0,0; parity 1; stop 1) -> key_data=0x1D, prev_data=0x00, one key_valid pulse.
REQ-029 SHALL pass: 0x1D, then 0xF0, then 0x1D -> key_valid pulses twice only; final key_data=0x00, prev_data=0x1D.
REQ-030 SHALL pass: 0x1D sent with parity 0 -> one frame_error pulse, no key_valid, key_data unchanged.
REQ-031 SHALL pass: 4 bits of a frame, then TIMEOUT_CYCLES idle cycles, then a good 0x75 frame -> one frame_error pulse, then key_data=0x75 with one key_valid pulse.
REQ-032 SHALL pass: a ps2_clk low glitch shorter than FILTER_LEN cycles in IDLE -> no state change, no pulses.
REQ-033 SHALL pass: rst_n pulsed low after bit 5 of a frame, then a good 0x6B frame -> all outputs 0 during reset, then key_data=0x6B.
